// File: rtl/rv_mem_pkg.sv
// Shared types and default sizes for the fetch/load-store memory arbiter.
package rv_mem_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and the shared single-port RAM bus.
// The arbiter uses the slave modport; requesters and the RAM drive the master side.
interface mem_arbiter_if
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  localparam int MASK_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [MASK_W-1:0] ram_wmask;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_wmask, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_wmask, busy
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between the fetch and load/store ports.
// On a tie the port that did not win last time is chosen.
module mem_arb_pick
  import rv_mem_pkg::*;
(
  input  logic   if_req_i,
  input  logic   mem_req_i,
  input  grant_e last_i,
  output grant_e winner_o
);

  always_comb begin
    winner_o = GNT_MEM;
    if (if_req_i && !mem_req_i) begin
      winner_o = GNT_IF;
    end else if (if_req_i && mem_req_i && (last_i == GNT_MEM)) begin
      winner_o = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port RAM between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise load/store always wins.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  grant_e            winner_q, winner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  grant_e            pick;
  grant_e            last;
  logic              anyReq;
  logic              issue;
  logic              ifAck;
  logic              memAck;

  assign anyReq = bus.if_req | bus.mem_req;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_IF;
    end else if (state_q == ST_IDLE && anyReq) begin
      last_q <= pick;
    end
  end

  assign last = last_q;
`else
  // Pretending IF always won last makes every tie go to load/store.
  assign last = GNT_IF;
`endif

  mem_arb_pick u_pick (
    .if_req_i  (bus.if_req),
    .mem_req_i (bus.mem_req),
    .last_i    (last),
    .winner_o  (pick)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          winner_d = pick;
          state_d  = ST_ISSUE;
          if (pick == GNT_MEM) begin
            addr_d  = bus.mem_addr;
            we_d    = bus.mem_we;
            wdata_d = bus.mem_wdata;
            wmask_d = bus.mem_wmask;
          end else begin
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (MEM_LAT == 1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        // Leaving as the count hits zero keeps WAIT at exactly MEM_LAT-1 cycles.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      winner_q <= GNT_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  assign issue  = (state_q == ST_ISSUE);
  assign ifAck  = (state_q == ST_RESP) && (winner_q == GNT_IF);
  assign memAck = (state_q == ST_RESP) && (winner_q == GNT_MEM);

  assign bus.ram_en    = issue;
  assign bus.ram_we    = issue & we_q;
  assign bus.ram_addr  = issue ? addr_q  : '0;
  assign bus.ram_wdata = issue ? wdata_q : '0;
  assign bus.ram_wmask = issue ? wmask_q : '0;

  assign bus.if_ack    = ifAck;
  assign bus.mem_ack   = memAck;
  assign bus.if_rdata  = ifAck  ? bus.ram_rdata : '0;
  assign bus.mem_rdata = memAck ? bus.ram_rdata : '0;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every output cycle by cycle.
module tb_mem_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int LAT = 3;

  typedef logic [255:0] word_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, a[31:0] + 32'h0000_0013};
  endfunction

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                               input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) begin
      if (mask[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    end
    return r;
  endfunction

  // Environment RAM: reads appear on ram_rdata exactly LAT cycles after ram_en.
  logic [DW-1:0] ramMem [logic [AW-1:0]];
  logic [DW-1:0] rdPipe [LAT];

  function automatic logic [DW-1:0] ramRead(input logic [AW-1:0] a);
    return ramMem.exists(a) ? ramMem[a] : initWord(a);
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) begin
      ramMem[bus.ram_addr] = mergeBytes(ramRead(bus.ram_addr), bus.ram_wdata, bus.ram_wmask);
    end
    if (rst) begin
      for (int i = 0; i < LAT; i++) rdPipe[i] <= '0;
    end else begin
      rdPipe[0] <= (bus.ram_en && !bus.ram_we) ? ramRead(bus.ram_addr) : '0;
      for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
  end

  assign bus.ram_rdata = rdPipe[LAT-1];

  // Reference memory and transaction-level timing model.
  logic [DW-1:0] refMem [logic [AW-1:0]];

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  int vecCount  = 0;
  int failCount = 0;
  int cyc, freeCyc, issueCyc, respCyc, respPort;
`ifdef ARB_ROUND_ROBIN_EN
  int lastGnt;
`endif
  logic          expWe;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata, expRdata;
  logic [MW-1:0] expWmask;

  // Requester records: index 0 = fetch port, 1 = load/store port.
  // pState: 0 idle, 1 waiting for grant, 2 granted and in flight.
  int            pState [2];
  logic          pReq   [2];
  logic [AW-1:0] pAddr  [2];
  logic          pWe    [2];
  logic [DW-1:0] pWdata [2];
  logic [MW-1:0] pWmask [2];

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    bus.if_req    = pReq[0];
    bus.if_addr   = pAddr[0];
    bus.mem_req   = pReq[1];
    bus.mem_addr  = pAddr[1];
    bus.mem_we    = pWe[1];
    bus.mem_wdata = pWdata[1];
    bus.mem_wmask = pWmask[1];
  endtask

  task automatic setRequest(input int p, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    pState[p] = 1;
    pReq[p]   = 1'b1;
    pAddr[p]  = a;
    pWe[p]    = (p == 1) ? we : 1'b0;
    pWdata[p] = wd;
    pWmask[p] = wm;
  endtask

  task automatic randomRequest(input int p);
    setRequest(p, AW'({$urandom_range(0, 15), 3'b000}), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, MW'($urandom));
  endtask

  task automatic resetModel();
    cyc      = 0;
    freeCyc  = 0;
    issueCyc = -1;
    respCyc  = -1;
    respPort = 0;
`ifdef ARB_ROUND_ROBIN_EN
    lastGnt  = 0;
`endif
    for (int p = 0; p < 2; p++) begin
      pState[p] = 0;
      pReq[p]   = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    resetModel();
    applyStimulus();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock cycle: update requesters, predict, check at the falling edge, advance.
  task automatic runCycle(input int newPct);
    int w;
    logic expBusy, expIssue, expResp;
    for (int p = 0; p < 2; p++) begin
      if (pState[p] == 0) begin
        if (int'($urandom_range(0, 99)) < newPct) randomRequest(p);
        else pReq[p] = 1'b0;
      end else if (pState[p] == 2 && $urandom_range(0, 99) < 25) begin
        pAddr[p]  = AW'({$urandom, $urandom});
        pWdata[p] = {$urandom, $urandom};
        pWmask[p] = MW'($urandom);
        pWe[p]    = (p == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if ($urandom_range(0, 1) == 0) pReq[p] = 1'b0;
      end
    end
    applyStimulus();

    if (cyc >= freeCyc && (pReq[0] || pReq[1])) begin
      if (pReq[0] && pReq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (lastGnt == 1) ? 0 : 1;
`else
        w = 1;
`endif
      end else begin
        w = pReq[1] ? 1 : 0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      lastGnt = w;
`endif
      pState[w] = 2;
      respPort  = w;
      issueCyc  = cyc + 1;
      respCyc   = cyc + LAT + 1;
      freeCyc   = cyc + LAT + 2;
      expAddr   = pAddr[w];
      expWe     = (w == 1) ? pWe[1] : 1'b0;
      expWdata  = (w == 1) ? pWdata[1] : '0;
      expWmask  = (w == 1) ? pWmask[1] : '0;
      if (expWe) refMem[expAddr] = mergeBytes(refRead(expAddr), expWdata, expWmask);
      else expRdata = refRead(expAddr);
    end

    @(negedge clk);
    expBusy  = (cyc >= issueCyc) && (cyc <= respCyc);
    expIssue = (cyc == issueCyc);
    expResp  = (cyc == respCyc);
    checkOutput("busy", word_t'(bus.busy), word_t'(expBusy));
    checkOutput("ram_en", word_t'(bus.ram_en), word_t'(expIssue));
    if (expIssue) begin
      checkOutput("ram_addr", word_t'(bus.ram_addr), word_t'(expAddr));
      checkOutput("ram_we", word_t'(bus.ram_we), word_t'(expWe));
      checkOutput("ram_wmask", word_t'(bus.ram_wmask), word_t'(expWmask));
      if (expWe) checkOutput("ram_wdata", word_t'(bus.ram_wdata), word_t'(expWdata));
    end else begin
      checkOutput("ram_idle", word_t'({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ram_wmask}), '0);
    end
    checkOutput("if_ack", word_t'(bus.if_ack), word_t'(expResp && respPort == 0));
    checkOutput("mem_ack", word_t'(bus.mem_ack), word_t'(expResp && respPort == 1));
    checkOutput("if_rdata", word_t'(bus.if_rdata),
                word_t'((expResp && respPort == 0) ? expRdata : '0));
    if (!(expResp && respPort == 1 && expWe)) begin
      checkOutput("mem_rdata", word_t'(bus.mem_rdata),
                  word_t'((expResp && respPort == 1) ? expRdata : '0));
    end
    if (expResp) pState[respPort] = 0;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runUntilIdle();
    for (int n = 0; n < 100 && (pState[0] != 0 || pState[1] != 0 || cyc < freeCyc); n++) begin
      runCycle(0);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pAddr[p]  = '0;
      pWe[p]    = 1'b0;
      pWdata[p] = '0;
      pWmask[p] = '0;
    end
    expWe    = 1'b0;
    expAddr  = '0;
    expWdata = '0;
    expRdata = '0;
    expWmask = '0;
    doReset();
    repeat (2) runCycle(0);

    setRequest(0, 64'h8000_0000, 1'b0, '0, '0);
    runUntilIdle();

    setRequest(1, 64'h100, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    runUntilIdle();
    setRequest(1, 64'h100, 1'b0, '0, '0);
    runUntilIdle();

    // Both ports keep requesting: exercises tie breaking and back-to-back grants.
    setRequest(0, 64'h200, 1'b0, '0, '0);
    setRequest(1, 64'h208, 1'b0, '0, '0);
    repeat (4 * (LAT + 2)) runCycle(100);
    runUntilIdle();

    repeat (600) runCycle(45);
    runUntilIdle();

    // Reset while the fetch sits in WAIT; nothing may be acknowledged afterwards.
    setRequest(0, 64'h40, 1'b0, '0, '0);
    repeat (3) runCycle(0);
    doReset();
    repeat (LAT + 3) runCycle(0);
    setRequest(0, 64'h48, 1'b0, '0, '0);
    runUntilIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 64, data width; MEM_LAT, default 1, RAM read latency in cycles (>=1).
REQ-002 Port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 Port rst, input, 1, reset, synchronous and active-high.
REQ-004 Ports if_req (in, 1) and if_addr (in, ADDR_W) SHALL form the instruction-fetch read request.
REQ-005 Ports if_rdata (out, DATA_W) and if_ack (out, 1) SHALL return the fetch response.
REQ-006 Ports mem_req (in, 1), mem_we (in, 1), mem_addr (in, ADDR_W), mem_wdata (in, DATA_W) and mem_wmask (in, DATA_W/8) SHALL form the load/store request.
REQ-007 Ports mem_rdata (out, DATA_W) and mem_ack (out, 1) SHALL return the load/store response.
REQ-008 Ports ram_en, ram_we (out, 1), ram_addr (out, ADDR_W), ram_wdata (out, DATA_W), ram_wmask (out, DATA_W/8) and ram_rdata (in, DATA_W) SHALL connect the single-port shared RAM.
REQ-009 Port busy (out, 1) SHALL be high whenever the FSM is not in IDLE.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-011 IDLE: if any req is high, the arbiter SHALL latch winner, address, we, wdata and wmask, then go to ISSUE; otherwise it stays in IDLE.
REQ-012 ISSUE: ram_en=1 for exactly one cycle with the latched fields; IF grants force ram_we=0 and ram_wmask=0.
REQ-013 ISSUE SHALL go to RESP if MEM_LAT==1; otherwise it goes to WAIT with a down-counter loaded to MEM_LAT-1.
REQ-014 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-015 RESP: the winner's ack=1 for exactly one cycle and its rdata = ram_rdata; the FSM then returns to IDLE.
REQ-016 Request-to-ack latency SHALL be MEM_LAT+1 cycles; back-to-back throughput is one transaction per MEM_LAT+2 cycles.
REQ-017 A requester SHALL hold req and its fields stable until ack; the arbiter ignores field changes after latching.
REQ-018 req still high in the cycle after ack SHALL be treated as a new request.
REQ-019 Writes SHALL receive an ack with identical timing; mem_rdata is don't-care on a write ack.
REQ-020 if_ack and mem_ack SHALL never be high in the same cycle, and ram_en SHALL never be high outside ISSUE.
REQ-021 A req dropped before ack (protocol violation) SHALL NOT abort the transaction; the ack is still issued.
REQ-022 Outputs ram_* SHALL be 0 outside ISSUE; if_rdata and mem_rdata SHALL be 0 outside their ack cycle.

Reset
REQ-023 rst high SHALL force state IDLE, counter 0, all outputs 0 and latched fields 0 on the next edge, including mid-transaction; no ack is issued for an aborted transaction.
REQ-024 The round-robin pointer SHALL reset to "last grant = IF", so the data port wins the first tie.

Configuration
REQ-025 Macro ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the port not granted last wins, and the pointer updates on every grant.
REQ-026 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority applies, mem_req always beats if_req, there is no pointer register, and IF starvation is permitted.

Structure
REQ-027 Package rv_mem_pkg SHALL hold the FSM state enum, the grant enum (GNT_IF, GNT_MEM) and the default width constants.
REQ-028 One combinational sub-module, mem_arb_pick (inputs: two reqs and the pointer; output: winner), SHALL contain the pick logic.

Verification
REQ-029 Single fetch, MEM_LAT=1: if_req=1 and if_addr=0x80000000 at cycle 0 -> ram_en=1 at cycle 1; RAM word 0x00000013 returned; if_ack=1 and if_rdata=0x13 at cycle 2.
REQ-030 Simultaneous requests, round robin: if_req=mem_req=1 held -> grant order MEM, IF, MEM, IF, with ack cycles at 2, 5, 8, 11.
REQ-031 Same stimulus without ARB_ROUND_ROBIN_EN -> only mem_ack pulses (2, 5, 8, ...) and if_ack stays 0.
REQ-032 Store: mem_we=1, mem_addr=0x100, wdata=0xDEADBEEF, wmask=0x0F -> ram_we=1 and ram_wmask=0x0F in ISSUE; a subsequent load of 0x100 returns 0xDEADBEEF.
REQ-033 MEM_LAT=3: a fetch request at cycle 0 -> ISSUE at cycle 1, WAIT during cycles 2-3, if_ack at cycle 4, busy=1 during cycles 1-4.
REQ-034 rst=1 during WAIT -> IDLE next cycle with all outputs 0 and no ack; a request after rst deasserts completes normally.
